// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter: FSM encoding, requester IDs and
// the round-robin grant rule.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  typedef enum logic {
    ReqFetch = 1'b0,
    ReqLsu   = 1'b1
  } req_id_e;

  localparam int unsigned DefaultTimeoutCycles = 255;

  // On a tie the requester that did not win last time gets the grant.
  function automatic req_id_e rr_pick(input logic fetch_req, input logic lsu_req,
                                      input req_id_e last_grant);
    if (fetch_req && lsu_req) begin
      return (last_grant == ReqFetch) ? ReqLsu : ReqFetch;
    end
    return lsu_req ? ReqLsu : ReqFetch;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundles the fetch, LSU and memory-side signals of the arbiter. The arbiter uses the
// master view; the surrounding requesters and memory use the slave view.
interface memory_arbiter_if;

  logic        fetch_req;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_done;
  logic        fetch_error;

  logic        lsu_req;
  logic        lsu_we;
  logic [31:0] lsu_address;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_mask;
  logic [31:0] lsu_rdata;
  logic        lsu_done;
  logic        lsu_error;

  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  fetch_req, fetch_address, lsu_req, lsu_we, lsu_address, lsu_wdata, lsu_mask,
           mem_rdata, mem_ready,
    output fetch_data, fetch_done, fetch_error, lsu_rdata, lsu_done, lsu_error,
           mem_valid, mem_we, mem_address, mem_wdata, mem_mask
  );

  modport slave (
    output fetch_req, fetch_address, lsu_req, lsu_we, lsu_address, lsu_wdata, lsu_mask,
           mem_rdata, mem_ready,
    input  fetch_data, fetch_done, fetch_error, lsu_rdata, lsu_done, lsu_error,
           mem_valid, mem_we, mem_address, mem_wdata, mem_mask
  );

endinterface

// File: rtl/arbiter_watchdog.sv
// BUSY-phase watchdog: counts enabled cycles from zero after a clear and flags expiry once
// the count reaches TIMEOUT_CYCLES-1.
module arbiter_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = memory_arbiter_pkg::DefaultTimeoutCycles
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_d, count_q;

  assign expired_o = (count_q == Limit);

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && !expired_o) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates the Fetch Unit and LSU onto a single memory port, one transaction at a time,
// with round-robin tie breaking and a BUSY watchdog that aborts a stalled access.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input logic               clk,
  input logic               reset,
  memory_arbiter_if.master  bus
);

  arb_state_e  state_d, state_q;
  req_id_e     grant_d, grant_q;
  req_id_e     last_grant_d, last_grant_q;
  logic        we_d, we_q;
  logic [31:0] addr_d, addr_q;
  logic [31:0] wdata_d, wdata_q;
  logic [3:0]  mask_d, mask_q;
  logic [31:0] data_d, data_q;
  logic        err_d, err_q;

  logic busy, resp, wd_clear, wd_expired;

  assign busy     = (state_q == StBusy);
  assign resp     = (state_q == StResp);
  assign wd_clear = !busy;

  arbiter_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (wd_clear),
    .enable_i (busy),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    data_d       = data_q;
    err_d        = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.fetch_req || bus.lsu_req) begin
          grant_d      = rr_pick(bus.fetch_req, bus.lsu_req, last_grant_q);
          last_grant_d = grant_d;
          state_d      = StBusy;
          if (grant_d == ReqLsu) begin
            we_d    = bus.lsu_we;
            addr_d  = bus.lsu_address;
            wdata_d = bus.lsu_wdata;
            mask_d  = bus.lsu_mask;
          end else begin
            we_d    = 1'b0;
            addr_d  = bus.fetch_address;
            wdata_d = '0;
            mask_d  = 4'b1111;
          end
        end
      end
      StBusy: begin
        // A ready on the watchdog's last cycle still counts as a normal completion.
        if (bus.mem_ready) begin
          data_d  = we_q ? '0 : bus.mem_rdata;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (wd_expired) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      grant_q      <= ReqFetch;
      last_grant_q <= ReqFetch;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  assign bus.mem_valid   = busy;
  assign bus.mem_we      = busy & we_q;
  assign bus.mem_address = busy ? addr_q : '0;
  assign bus.mem_wdata   = busy ? wdata_q : '0;
  assign bus.mem_mask    = busy ? mask_q : '0;

  assign bus.fetch_done  = resp && (grant_q == ReqFetch);
  assign bus.fetch_data  = bus.fetch_done ? data_q : '0;
  assign bus.fetch_error = bus.fetch_done & err_q;
  assign bus.lsu_done    = resp && (grant_q == ReqLsu);
  assign bus.lsu_rdata   = bus.lsu_done ? data_q : '0;
  assign bus.lsu_error   = bus.lsu_done & err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a transaction-level model predicts each grant,
// memory request and completion; separate monitors compare what the DUT presents.
module tb_memory_arbiter;

  localparam int Timeout = 8;

  logic clk = 1'b0;
  logic reset;

  memory_arbiter_if bus ();

  memory_arbiter #(
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          start;
    int          len;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        chk_wdata;
  } mem_exp_t;

  typedef struct packed {
    int          cyc;
    logic        is_lsu;
    logic [31:0] data;
    logic        err;
  } resp_exp_t;

  typedef struct packed {
    int          d;
    logic [31:0] rdata;
  } mem_plan_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  mem_plan_t plan_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int free_at = 0;
  bit last_lsu = 1'b0;
  bit rst_prev = 1'b0;
  int force_d = -1;
  bit force_rd_en = 1'b0;
  logic [31:0] force_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick_delay();
    case ($urandom_range(0, 9))
      0, 1, 2: return 0;
      3:       return 1;
      4:       return 2;
      5:       return 3;
      6:       return 5;
      7:       return Timeout - 1;
      8:       return Timeout;
      default: return Timeout + 3;
    endcase
  endfunction

  // Model: the arbiter is free at cycle free_at; a grant there occupies the port for
  // 1 + min(d, Timeout-1) BUSY cycles plus one response cycle.
  always @(posedge clk) begin : model
    mem_exp_t    me;
    resp_exp_t   re;
    mem_plan_t   mp;
    bit          g_lsu;
    int          d;
    int          dur;
    logic [31:0] rd;
    if (reset) begin
      free_at  = cyc + 1;
      last_lsu = 1'b0;
      mem_q.delete();
      resp_q.delete();
      plan_q.delete();
    end else if (cyc == free_at) begin
      if (bus.fetch_req || bus.lsu_req) begin
        g_lsu    = (bus.fetch_req && bus.lsu_req) ? !last_lsu : bus.lsu_req;
        last_lsu = g_lsu;
        d        = (force_d >= 0) ? force_d : pick_delay();
        rd       = force_rd_en ? force_rd : $urandom;
        dur      = (d < Timeout) ? d : Timeout - 1;
        me.start = cyc + 1;
        me.len   = dur + 1;
        if (g_lsu) begin
          me.we        = bus.lsu_we;
          me.addr      = bus.lsu_address;
          me.wdata     = bus.lsu_wdata;
          me.mask      = bus.lsu_mask;
          me.chk_wdata = 1'b1;
        end else begin
          me.we        = 1'b0;
          me.addr      = bus.fetch_address;
          me.wdata     = '0;
          me.mask      = 4'b1111;
          me.chk_wdata = 1'b0;
        end
        re.cyc    = cyc + 2 + dur;
        re.is_lsu = g_lsu;
        re.err    = (d >= Timeout);
        re.data   = (re.err || (g_lsu && bus.lsu_we)) ? 32'h0 : rd;
        mp.d      = d;
        mp.rdata  = rd;
        mem_q.push_back(me);
        resp_q.push_back(re);
        plan_q.push_back(mp);
        free_at = cyc + 3 + dur;
      end else begin
        free_at = cyc + 1;
      end
    end
    rst_prev = reset;
    cyc++;
  end

  // Memory responder: raises mem_ready on BUSY cycle index d of the planned access and
  // toggles mem_ready randomly while no request is presented.
  always @(negedge clk) begin : responder
    int        idx;
    bit        have_plan;
    mem_plan_t cur;
    if (rst_prev || bus.mem_valid !== 1'b1) begin
      idx           = 0;
      have_plan     = 1'b0;
      bus.mem_ready = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
    end else begin
      if (idx == 0) begin
        have_plan = (plan_q.size() > 0);
        if (have_plan) cur = plan_q.pop_front();
      end
      bus.mem_ready = have_plan && (idx == cur.d);
      bus.mem_rdata = bus.mem_ready ? cur.rdata : $urandom;
      idx++;
    end
  end

  always @(negedge clk) begin : mem_monitor
    int       busy_left;
    mem_exp_t cur;
    mem_exp_t dropped;
    if (rst_prev) begin
      busy_left = 0;
      chk("reset_outputs_zero",
          32'(|{bus.mem_valid, bus.mem_we, bus.mem_address, bus.mem_wdata, bus.mem_mask,
                bus.fetch_data, bus.fetch_done, bus.fetch_error,
                bus.lsu_rdata, bus.lsu_done, bus.lsu_error}), 32'h0);
    end else if (bus.mem_valid === 1'b1) begin
      if (busy_left == 0) begin
        if (mem_q.size() == 0) begin
          chk("mem_valid_unexpected", 32'(bus.mem_valid), 32'h0);
        end else begin
          cur = mem_q.pop_front();
          chk("mem_start_cycle", cyc, cur.start);
          busy_left = cur.len;
        end
      end
      if (busy_left > 0) begin
        chk("mem_we", 32'(bus.mem_we), 32'(cur.we));
        chk("mem_address", bus.mem_address, cur.addr);
        chk("mem_mask", 32'(bus.mem_mask), 32'(cur.mask));
        if (cur.chk_wdata) chk("mem_wdata", bus.mem_wdata, cur.wdata);
        busy_left--;
      end
    end else begin
      if (busy_left > 0) begin
        chk("mem_valid_held", 32'(bus.mem_valid), 32'h1);
        busy_left = 0;
      end else if (mem_q.size() > 0 && mem_q[0].start < cyc) begin
        dropped = mem_q.pop_front();
        chk("mem_start_cycle", cyc, dropped.start);
      end
    end
  end

  always @(negedge clk) begin : resp_monitor
    resp_exp_t re;
    if (!rst_prev) begin
      if (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
        re = resp_q.pop_front();
        chk("done_cycle_missed", cyc, re.cyc);
      end
      if (bus.fetch_done === 1'b1 || bus.lsu_done === 1'b1) begin
        if (resp_q.size() == 0) begin
          chk("done_unexpected", 32'({bus.fetch_done, bus.lsu_done}), 32'h0);
        end else begin
          re = resp_q.pop_front();
          chk("done_cycle", cyc, re.cyc);
          chk("fetch_done", 32'(bus.fetch_done), 32'(!re.is_lsu));
          chk("lsu_done", 32'(bus.lsu_done), 32'(re.is_lsu));
          if (re.is_lsu) begin
            chk("lsu_rdata", bus.lsu_rdata, re.data);
            chk("lsu_error", 32'(bus.lsu_error), 32'(re.err));
            chk("fetch_quiet", bus.fetch_data | 32'(bus.fetch_error), 32'h0);
          end else begin
            chk("fetch_data", bus.fetch_data, re.data);
            chk("fetch_error", 32'(bus.fetch_error), 32'(re.err));
            chk("lsu_quiet", bus.lsu_rdata | 32'(bus.lsu_error), 32'h0);
          end
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] addr);
    int n;
    bus.fetch_address = addr;
    bus.fetch_req     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.fetch_done !== 1'b1 && n < 200);
    if (n >= 200) chk("fetch_done_wait", 32'(bus.fetch_done), 32'h1);
    bus.fetch_req = 1'b0;
  endtask

  task automatic do_lsu(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] mask);
    int n;
    bus.lsu_we      = we;
    bus.lsu_address = addr;
    bus.lsu_wdata   = wdata;
    bus.lsu_mask    = mask;
    bus.lsu_req     = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.lsu_done !== 1'b1 && n < 200);
    if (n >= 200) chk("lsu_done_wait", 32'(bus.lsu_done), 32'h1);
    bus.lsu_req = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    bus.fetch_req     = 1'b0;
    bus.fetch_address = '0;
    bus.lsu_req       = 1'b0;
    bus.lsu_we        = 1'b0;
    bus.lsu_address   = '0;
    bus.lsu_wdata     = '0;
    bus.lsu_mask      = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single fetch with zero-wait memory.
    force_d     = 0;
    force_rd_en = 1'b1;
    force_rd    = 32'hDEADBEEF;
    do_fetch(32'h100);
    force_rd_en = 1'b0;

    // Contention straight out of reset: LSU first, then alternating.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    fork
      for (int i = 0; i < 4; i++) do_fetch(32'h1000 + 32'(4 * i));
      for (int j = 0; j < 4; j++) do_lsu(1'b0, 32'h3000 + 32'(4 * j), $urandom, 4'hF);
    join

    // Partial-mask store.
    do_lsu(1'b1, 32'h2000, 32'h12345678, 4'b0011);

    // Memory never ready: watchdog abort.
    force_d = 50;
    do_fetch(32'h500);
    do_lsu(1'b0, 32'h504, 32'h0, 4'hF);

    // Ready on the final watchdog cycle.
    force_d = Timeout - 1;
    do_lsu(1'b0, 32'h600, 32'h0, 4'hF);
    do_fetch(32'h604);

    // Reset while BUSY, then the still-held fetch is served again.
    force_d = 40;
    fork
      do_fetch(32'h700);
      begin
        for (int k = 0; k < 20 && bus.mem_valid !== 1'b1; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        force_d = 0;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    join

    // Random traffic.
    force_d = -1;
    fork
      for (int a = 0; a < 30; a++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_fetch($urandom);
      end
      for (int b = 0; b < 30; b++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_lsu(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
      end
    join

    repeat (5) @(negedge clk);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'h0);
    chk("resp_queue_drained", 32'(resp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles before a transaction aborts with error.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 fetch_req  input  1  Fetch Unit read request; held until fetch_done.
REQ-005 fetch_address  input  32  fetch word address.
REQ-006 fetch_data  output  32  fetched word, valid while fetch_done=1.
REQ-007 fetch_done  output  1  one-cycle completion pulse to Fetch Unit.
REQ-008 fetch_error  output  1  qualifies fetch_done; 1 means timeout.
REQ-009 lsu_req  input  1  Load Store Unit request; held until lsu_done.
REQ-010 lsu_we  input  1  1 = store, 0 = load.
REQ-011 lsu_address  input  32  data address.
REQ-012 lsu_wdata  input  32  store data.
REQ-013 lsu_mask  input  4  byte enables.
REQ-014 lsu_rdata  output  32  load data, valid while lsu_done=1; 0 for stores.
REQ-015 lsu_done  output  1  one-cycle completion pulse to LSU.
REQ-016 lsu_error  output  1  qualifies lsu_done; 1 means timeout.
REQ-017 mem_valid  output  1  memory request valid.
REQ-018 mem_we  output  1  memory write enable.
REQ-019 mem_address  output  32  memory address.
REQ-020 mem_wdata  output  32  memory write data.
REQ-021 mem_mask  output  4  memory byte enables.
REQ-022 mem_rdata  input  32  memory read data, sampled when mem_valid & mem_ready.
REQ-023 mem_ready  input  1  memory accepts/completes current request.

Function
REQ-024 FSM states IDLE, BUSY, RESP; single outstanding transaction.
REQ-025 IDLE: if any request, latch winner's attributes into registers, go BUSY next edge; else stay IDLE.
REQ-026 Both requests in IDLE: grant requester not granted last (round-robin); last_grant resets to FETCH, so LSU wins the first tie.
REQ-027 Fetch grant drives mem_we=0, mem_mask=4'b1111.
REQ-028 BUSY: mem_valid=1, mem_* from latched registers, stable until exit.
REQ-029 BUSY with mem_ready=1: capture mem_rdata (0 if write), go RESP, mem_valid=0 next cycle.
REQ-030 BUSY watchdog counts from 0 on entry; reaching TIMEOUT_CYCLES-1 without mem_ready -> RESP, error=1, data=0.
REQ-031 mem_ready on the same cycle the watchdog expires: normal completion, no error.
REQ-032 RESP lasts exactly one cycle: granted requester's done=1 with data/error; other requester's outputs 0; go IDLE.
REQ-033 Requester updates req on the edge ending its done cycle; IDLE next cycle samples updated req, no double issue.
REQ-034 Minimum latency: req in IDLE at cycle 0, mem_valid cycle 1, mem_ready cycle 1 -> done cycle 2; back-to-back throughput one transaction per 3 cycles.
REQ-035 mem_ready while mem_valid=0 ignored; requests arriving during BUSY/RESP wait in IDLE.

Reset
REQ-036 reset=1 forces IDLE, last_grant=FETCH, watchdog=0, all outputs 0 on next edge.
REQ-037 Reset mid-BUSY aborts silently: mem_valid low next cycle, no done pulse issued.

Structure
REQ-038 Shared package holds FSM state encoding, requester IDs (FETCH, LSU), default TIMEOUT_CYCLES.
REQ-039 Watchdog is one sub-module, arbiter_watchdog (clear, enable, expired), parameterised by TIMEOUT_CYCLES.

Verification
REQ-040 Fetch-only, addr 0x100, mem_ready at cycle 1, rdata 0xDEADBEEF -> fetch_done cycle 2, fetch_data 0xDEADBEEF, error 0.
REQ-041 Both request from reset -> LSU served first, then fetch; continued contention alternates grants.
REQ-042 LSU store addr 0x2000, wdata 0x12345678, mask 4'b0011 -> mem_we=1, fields match; lsu_done, lsu_rdata=0.
REQ-043 mem_ready held low, TIMEOUT_CYCLES=8 -> done with error=1 after 8 BUSY cycles, mem_valid drops.
REQ-044 mem_ready on the watchdog's final BUSY cycle -> completes without error.
REQ-045 reset asserted in BUSY -> mem_valid 0 next cycle, no done; new fetch then served normally.
